// File: rtl/local_history_predictor_param_pkg.sv
// Shared types and helpers for the lc3b parametrised local-history branch predictor.
package local_history_predictor_param_pkg;

   localparam int unsigned LC3B_WORD_W = 16;

   typedef logic [LC3B_WORD_W-1:0] lc3b_word;

   typedef enum logic {
      PRED_INIT = 1'b0,
      PRED_RUN  = 1'b1
   } pred_state_t;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/local_history_predictor_param_sat_counter_table.sv
// Pattern table of saturating counters: combinational read, read-modify-write
// update and a sweep-init write port. Contents are intentionally not reset.
module local_history_predictor_param_sat_counter_table #(
   parameter int unsigned DEPTH_BITS = 4,
   parameter int unsigned CTR_BITS   = 2,
   parameter int unsigned INIT_VAL   = 1
) (
   input  logic                  clk,
   input  logic [DEPTH_BITS-1:0] rd_idx_i,
   output logic [CTR_BITS-1:0]   rd_ctr_c,
   input  logic                  upd_en_i,
   input  logic [DEPTH_BITS-1:0] upd_idx_i,
   input  logic                  upd_taken_i,
   input  logic                  init_en_i,
   input  logic [DEPTH_BITS-1:0] init_idx_i
);

   localparam int unsigned         DEPTH   = 2 ** DEPTH_BITS;
   localparam logic [CTR_BITS-1:0] CTR_MAX = '1;

   logic [CTR_BITS-1:0] ctr_q [DEPTH];
   logic [CTR_BITS-1:0] upd_old_c;
   logic [CTR_BITS-1:0] upd_new_c;

   assign rd_ctr_c  = ctr_q[rd_idx_i];
   assign upd_old_c = ctr_q[upd_idx_i];

   // Saturating step toward the resolved outcome.
   always_comb begin
      upd_new_c = upd_old_c;
      if (upd_taken_i && (upd_old_c != CTR_MAX)) begin
         upd_new_c = upd_old_c + CTR_BITS'(1);
      end else if (!upd_taken_i && (upd_old_c != '0)) begin
         upd_new_c = upd_old_c - CTR_BITS'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (init_en_i) begin
         ctr_q[init_idx_i] <= CTR_BITS'(INIT_VAL);
      end else if (upd_en_i) begin
         ctr_q[upd_idx_i] <= upd_new_c;
      end
   end

endmodule

// File: rtl/local_history_predictor_param.sv
// Two-level local branch predictor: BHT of per-branch histories indexing a PHT of
// saturating counters, with post-reset table sweep and a saturating mispredict counter.
module local_history_predictor_param
   import local_history_predictor_param_pkg::*;
#(
   parameter int unsigned BHT_IDX_BITS = 4,
   parameter int unsigned HIST_LEN     = 4,
   parameter int unsigned CTR_BITS     = 2,
   parameter int unsigned PC_XOR       = 0,
   parameter int unsigned STAT_BITS    = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  lc3b_word             lookup_pc,
   output logic                 predict_taken,
   output logic                 ready,
   input  logic                 update_branch_history,
   input  lc3b_word             resolved_pc,
   input  logic                 wb_take_jump,
   input  logic                 wb_predicted_taken,
   input  logic                 clear_stats,
   output logic [STAT_BITS-1:0] mispredict_count
);

   localparam int unsigned          BHT_N     = 2 ** BHT_IDX_BITS;
   localparam int unsigned          PHT_N     = 2 ** HIST_LEN;
   localparam int unsigned          IDX_W     = max_u(BHT_IDX_BITS, HIST_LEN);
   localparam int unsigned          WNT       = (2 ** (CTR_BITS - 1)) - 1;
   localparam logic [IDX_W-1:0]     INIT_LAST = '1;
   localparam logic [STAT_BITS-1:0] STAT_MAX  = '1;

   pred_state_t          state_q, state_d;
   logic [IDX_W-1:0]     init_idx_q, init_idx_d;
   logic                 ready_q, ready_d;
   logic [STAT_BITS-1:0] count_q, count_d;

   logic [HIST_LEN-1:0]     bht_q [BHT_N];
   logic [BHT_IDX_BITS-1:0] lookup_bht_idx, upd_bht_idx;
   logic [HIST_LEN-1:0]     lookup_hist, upd_hist, upd_hist_new;
   logic [HIST_LEN-1:0]     lookup_pht_idx, upd_pht_idx;
   logic [CTR_BITS-1:0]     lookup_ctr;
   logic                    upd_en, bht_init_en, pht_init_en;
   logic                    unused_bits;

   assign upd_en      = update_branch_history & ready_q;
   assign bht_init_en = (state_q == PRED_INIT) && (32'(init_idx_q) < BHT_N);
   assign pht_init_en = (state_q == PRED_INIT) && (32'(init_idx_q) < PHT_N);

   assign lookup_bht_idx = lookup_pc[BHT_IDX_BITS:1];
   assign upd_bht_idx    = resolved_pc[BHT_IDX_BITS:1];
   assign lookup_hist    = bht_q[lookup_bht_idx];
   assign upd_hist       = bht_q[upd_bht_idx];
   assign lookup_pht_idx = (PC_XOR != 0) ? (lookup_hist ^ lookup_pc[HIST_LEN:1]) : lookup_hist;
   assign upd_pht_idx    = (PC_XOR != 0) ? (upd_hist ^ resolved_pc[HIST_LEN:1]) : upd_hist;

   generate
      if (HIST_LEN == 1) begin : g_hist1
         assign upd_hist_new = wb_take_jump;
      end else begin : g_histn
         assign upd_hist_new = {upd_hist[HIST_LEN-2:0], wb_take_jump};
      end
   endgenerate

   // BHT storage; init sweep and updates never overlap since updates need ready.
   always_ff @(posedge clk) begin
      if (bht_init_en) begin
         bht_q[init_idx_q[BHT_IDX_BITS-1:0]] <= '0;
      end else if (upd_en) begin
         bht_q[upd_bht_idx] <= upd_hist_new;
      end
   end

   local_history_predictor_param_sat_counter_table #(
      .DEPTH_BITS (HIST_LEN),
      .CTR_BITS   (CTR_BITS),
      .INIT_VAL   (WNT)
   ) u_pht (
      .clk         (clk),
      .rd_idx_i    (lookup_pht_idx),
      .rd_ctr_c    (lookup_ctr),
      .upd_en_i    (upd_en),
      .upd_idx_i   (upd_pht_idx),
      .upd_taken_i (wb_take_jump),
      .init_en_i   (pht_init_en),
      .init_idx_i  (init_idx_q[HIST_LEN-1:0])
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= PRED_INIT;
         init_idx_q <= '0;
         ready_q    <= 1'b0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         init_idx_q <= init_idx_d;
         ready_q    <= ready_d;
         count_q    <= count_d;
      end
   end

   // Init sweep walks every entry of the larger table, then predictor runs until reset.
   always_comb begin
      state_d    = state_q;
      init_idx_d = init_idx_q;
      ready_d    = ready_q;
      count_d    = count_q;
      unique case (state_q)
         PRED_INIT: begin
            init_idx_d = init_idx_q + IDX_W'(1);
            if (init_idx_q == INIT_LAST) begin
               state_d = PRED_RUN;
               ready_d = 1'b1;
            end
         end
         PRED_RUN: begin
            if (clear_stats) begin
               count_d = '0;
            end else if (upd_en && (wb_take_jump != wb_predicted_taken) &&
                         (count_q != STAT_MAX)) begin
               count_d = count_q + STAT_BITS'(1);
            end
         end
      endcase
   end

   assign predict_taken    = ready_q & lookup_ctr[CTR_BITS-1];
   assign ready            = ready_q;
   assign mispredict_count = count_q;

   assign unused_bits = ^{lookup_pc, resolved_pc, lookup_ctr};

endmodule
